// File: rtl/ysyx_22040759_ifu.sv
// rtl/ysyx_22040759_ifu.sv - instruction fetch unit: PC, one-outstanding imem fetch, decode handoff
// Redirects from execute override sequential flow and kill any fetch already in flight.
module ysyx_22040759_ifu #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_o,
   output logic [63:0] pc_o,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic        kill_q, kill_d;
   logic        pend_vld_q, pend_vld_d;
   logic [63:0] pend_pc_q, pend_pc_d;
   logic [31:0] inst_q, inst_d;
   logic [63:0] pc_out_q, pc_out_d;

   logic [63:0] target;
   logic        req_hs;

   assign target = {redirect_pc[63:2], 2'b00};
   assign req_hs = (state_q == S_REQ) && imem_req_ready;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      kill_d     = kill_q;
      pend_vld_d = pend_vld_q;
      pend_pc_d  = pend_pc_q;
      inst_d     = inst_q;
      pc_out_d   = pc_out_q;

      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
            if (redirect_valid) begin
               pc_d = target;
            end
         end

         S_REQ: begin
            if (req_hs) begin
               state_d    = S_WAIT;
               pend_vld_d = 1'b0;
               if (redirect_valid) begin
                  pc_d   = target;
                  kill_d = 1'b1;
               end else if (pend_vld_q) begin
                  pc_d = pend_pc_q;
               end
            end else if (redirect_valid) begin
               // The address must stay stable until accepted, so park the target.
               pend_pc_d  = target;
               pend_vld_d = 1'b1;
               kill_d     = 1'b1;
            end
         end

         S_WAIT: begin
            if (redirect_valid) begin
               pc_d = target;
               if (imem_rsp_valid) begin
                  kill_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  kill_d = 1'b1;
               end
            end else if (imem_rsp_valid) begin
               if (kill_q) begin
                  kill_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  inst_d   = imem_rsp_data;
                  pc_out_d = pc_q;
                  state_d  = S_HOLD;
               end
            end
         end

         S_HOLD: begin
            if (redirect_valid) begin
               inst_d  = NOP_INST;
               pc_d    = target;
               state_d = S_REQ;
            end else if (inst_ready) begin
               inst_d  = NOP_INST;
               pc_d    = pc_q + 64'd4;
               state_d = S_REQ;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         kill_q     <= 1'b0;
         pend_vld_q <= 1'b0;
         pend_pc_q  <= RESET_PC;
         inst_q     <= NOP_INST;
         pc_out_q   <= RESET_PC;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         kill_q     <= kill_d;
         pend_vld_q <= pend_vld_d;
         pend_pc_q  <= pend_pc_d;
         inst_q     <= inst_d;
         pc_out_q   <= pc_out_d;
      end
   end

   assign imem_req_valid = (state_q == S_REQ);
   assign imem_req_addr  = pc_q;
   assign inst_valid     = (state_q == S_HOLD);
   assign inst_o         = inst_q;
   assign pc_o           = pc_out_q;

endmodule
